// File: rtl/fpu_pkg.sv
// fpu_pkg: binary32 field widths, exponent bias and rounding-mode encodings shared by the FPU blocks.
package fpu_pkg;
   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RDN = 2'b10;
   localparam logic [1:0] RM_RUP = 2'b11;
   localparam int FP32_BIAS   = 127;
   localparam int FP32_MANT_W = 23;
   localparam int FP32_EXP_W  = 8;
endpackage

// File: rtl/itof_lzc.sv
// itof_lzc: leading-zero count of a W-bit word; lz = W and zero = 1 for an all-zero input.
module itof_lzc #(
   parameter int W  = 32,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  d,
   output logic [CW-1:0] lz,
   output logic          zero
);
   always_comb begin
      lz = CW'(W);
      for (int i = 0; i < W; i++)
         if (d[i]) lz = CW'(W - 1 - i);
   end
   assign zero = ~|d;
endmodule

// File: rtl/itof_stream.sv
// itof_stream: 3-stage valid/ready pipeline converting a signed/unsigned integer to IEEE-754 binary32.
module itof_stream
   import fpu_pkg::*;
#(
   parameter int IN_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_data,
   input  logic            in_signed,
   input  logic [1:0]      in_rm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_data,
   output logic            out_inexact
);
   localparam int LAT = 3;
   localparam int CW  = $clog2(IN_W + 1);
   localparam int NW  = IN_W + FP32_MANT_W + 2;

   logic [LAT-1:0]         vld;
   logic                   en;
   logic                   in_neg;
   logic                   s1_sign;
   logic [IN_W-1:0]        s1_mag;
   logic [1:0]             s1_rm;
   logic [CW-1:0]          lz;
   logic                   lz_zero;
   logic [NW-1:0]          norm;
   logic                   s2_sign;
   logic                   s2_zero;
   logic                   s2_guard;
   logic                   s2_sticky;
   logic [1:0]             s2_rm;
   logic [FP32_EXP_W-1:0]  s2_exp;
   logic [FP32_MANT_W-1:0] s2_mant;
   logic                   inc;
   logic [FP32_MANT_W:0]   rnd;
   logic [31:0]            res;

   assign en        = ~vld[LAT-1] | out_ready;
   assign in_ready  = en;
   assign out_valid = vld[LAT-1];
   assign in_neg    = in_signed & in_data[IN_W-1];

   always_ff @(posedge clk)
      if (!reset) vld <= '0;
      else if (en) vld <= {vld[LAT-2:0], in_valid};

   // Magnitude stays IN_W wide: the most negative value negates to 2^(IN_W-1) unsigned.
   always_ff @(posedge clk)
      if (!reset) begin
         s1_sign <= 1'b0;
         s1_mag  <= '0;
         s1_rm   <= '0;
      end else if (en) begin
         s1_sign <= in_neg;
         s1_mag  <= in_neg ? -in_data : in_data;
         s1_rm   <= in_rm;
      end

   itof_lzc #(.W(IN_W), .CW(CW)) u_lzc (
      .d    (s1_mag),
      .lz   (lz),
      .zero (lz_zero)
   );

   // Shifting one past the leading one drops the hidden bit; mantissa, guard and sticky follow.
   assign norm = {s1_mag, {(FP32_MANT_W + 2){1'b0}}} << (int'(lz) + 1);

   always_ff @(posedge clk)
      if (!reset) begin
         s2_sign   <= 1'b0;
         s2_zero   <= 1'b1;
         s2_rm     <= '0;
         s2_exp    <= '0;
         s2_mant   <= '0;
         s2_guard  <= 1'b0;
         s2_sticky <= 1'b0;
      end else if (en) begin
         s2_sign   <= s1_sign;
         s2_zero   <= lz_zero;
         s2_rm     <= s1_rm;
         s2_exp    <= FP32_EXP_W'(FP32_BIAS + IN_W - 1 - int'(lz));
         s2_mant   <= norm[NW-1 -: FP32_MANT_W];
         s2_guard  <= norm[NW-1-FP32_MANT_W];
         s2_sticky <= |norm[NW-2-FP32_MANT_W:0];
      end

   // Truncation (RTZ) is the fall-through case; a mantissa carry-out leaves zeros behind and bumps the exponent.
   always_comb begin
      inc = (s2_rm == RM_RNE) ? s2_guard & (s2_sticky | s2_mant[0]) :
            (s2_rm == RM_RDN) ? s2_sign & (s2_guard | s2_sticky) :
            (s2_rm == RM_RUP) ? ~s2_sign & (s2_guard | s2_sticky) : 1'b0;
      rnd = {1'b0, s2_mant} + {{FP32_MANT_W{1'b0}}, inc};
      res = s2_zero ? '0 : {s2_sign, s2_exp + FP32_EXP_W'(rnd[FP32_MANT_W]), rnd[FP32_MANT_W-1:0]};
   end

   always_ff @(posedge clk)
      if (!reset) begin
         out_data    <= '0;
         out_inexact <= 1'b0;
      end else if (en) begin
         out_data    <= res;
         out_inexact <= s2_guard | s2_sticky;
      end
endmodule

// File: tb/tb_itof_stream.sv
// tb_itof_stream: randomized and directed checks of itof_stream at IN_W = 16, 32 and 64 against an arithmetic model.
module tb_itof_stream;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_signed = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  in_rm = 2'd0;
   logic [63:0] din = 64'd0;

   logic        rdy16, rdy32, rdy64;
   logic        ov16, ov32, ov64;
   logic [31:0] od16, od32, od64;
   logic        oi16, oi32, oi64;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   itof_stream #(.IN_W(16)) u16 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy16), .in_data(din[15:0]),
      .in_signed(in_signed), .in_rm(in_rm), .out_valid(ov16), .out_ready(out_ready),
      .out_data(od16), .out_inexact(oi16));
   itof_stream #(.IN_W(32)) u32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .in_data(din[31:0]),
      .in_signed(in_signed), .in_rm(in_rm), .out_valid(ov32), .out_ready(out_ready),
      .out_data(od32), .out_inexact(oi32));
   itof_stream #(.IN_W(64)) u64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64), .in_data(din),
      .in_signed(in_signed), .in_rm(in_rm), .out_valid(ov64), .out_ready(out_ready),
      .out_data(od64), .out_inexact(oi64));

   // Exact integer rounding: quotient/remainder against the half-ulp, returns {inexact, binary32}.
   function automatic logic [32:0] ref_itof(input logic [63:0] x, input int w, input logic sg, input logic [1:0] rm);
      logic [63:0] v, mag, q, rem, half;
      logic neg, up;
      int p, sh;
      v = (w == 64) ? x : (x & ((64'd1 << w) - 64'd1));
      neg = sg & v[w-1];
      mag = neg ? ((64'd1 << w) - v) : v;
      if (mag == 64'd0) return 33'd0;
      p = 63;
      while (!mag[p]) p--;
      rem = 64'd0;
      q = mag;
      if (p <= 23) q = mag << (23 - p);
      else begin
         sh = p - 23;
         q = mag >> sh;
         rem = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         case (rm)
            2'd0: up = (rem > half) || (rem == half && q[0]);
            2'd1: up = 1'b0;
            2'd2: up = neg && rem != 64'd0;
            default: up = !neg && rem != 64'd0;
         endcase
         q = q + 64'(up);
         if (q[24]) begin
            q = q >> 1;
            p++;
         end
      end
      return {rem != 64'd0, neg, 8'(127 + p), q[22:0]};
   endfunction

   logic [31:0] dv [12] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,
                            32'h0, 32'h0, 32'h01000001, 32'h01000003, 32'h01000001, 32'hFEFFFFFF};
   logic        ds [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [1:0]  dr [12] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3, 2'd2};
   logic [31:0] de [12] = '{32'h4F000000, 32'h4EFFFFFF, 32'hCF000000, 32'h4F800000, 32'h0, 32'h0,
                            32'h0, 32'h0, 32'h4B800000, 32'h4B800002, 32'h4B800001, 32'hCB800001};
   logic        di [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   task automatic send_one(input logic [63:0] d, input logic sg, input logic [1:0] rm,
                           output logic [31:0] od, output logic oi, output int lat);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      din = d;
      in_signed = sg;
      in_rm = rm;
      lat = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!ov32 && lat < 10);
      od = od32;
      oi = oi32;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_checks += 3;
         if (ov32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov32); end
         if (od32 !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 00000000", od32); end
         if (oi32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_inexact got %b want 0", oi32); end
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", rdy32); end
   endtask

   task automatic test_directed();
      logic [31:0] od;
      logic oi;
      int lat;
      for (int i = 0; i < 12; i++) begin
         send_one(64'(dv[i]), ds[i], dr[i], od, oi, lat);
         n_checks += 3;
         if (lat != 3) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want 3", i, lat); end
         if (od !== de[i]) begin n_fail++; $display("FAIL directed_data[%0d] got %h want %h", i, od, de[i]); end
         if (oi !== di[i]) begin n_fail++; $display("FAIL directed_inexact[%0d] got %b want %b", i, oi, di[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] ops [5];
      logic [1:0] rms [5];
      logic sgs [5];
      logic [32:0] ex, hv;
      logic held;
      int sent, recv;
      held = 1'b0;
      hv = 33'd0;
      sent = 0;
      recv = 0;
      for (int i = 0; i < 5; i++) begin
         ops[i] = $urandom;
         rms[i] = 2'($urandom_range(0, 3));
         sgs[i] = 1'($urandom_range(0, 1));
      end
      for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 6);
         in_valid = (sent < 5);
         if (sent < 5) begin
            din = 64'(ops[sent]);
            in_signed = sgs[sent];
            in_rm = rms[sent];
         end
         #1;
         if (cyc == 5) begin
            n_checks++;
            if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %b want 0", rdy32); end
         end
         if (ov32 && !out_ready) begin
            if (held) begin
               n_checks++;
               if ({oi32, od32} !== hv) begin n_fail++; $display("FAIL bp_stable got %h want %h", {oi32, od32}, hv); end
            end
            hv = {oi32, od32};
            held = 1'b1;
         end
         if (ov32 && out_ready) begin
            ex = ref_itof(64'(ops[recv]), 32, sgs[recv], rms[recv]);
            n_checks++;
            if ({oi32, od32} !== ex) begin n_fail++; $display("FAIL bp_result[%0d] got %h want %h", recv, {oi32, od32}, ex); end
            recv++;
         end
         if (in_valid && rdy32) sent++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (recv != 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", recv); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] od;
      logic oi;
      int lat;
      logic [32:0] ex;
      out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         in_valid = 1'b1;
         din = 64'($urandom);
         in_signed = 1'($urandom_range(0, 1));
         in_rm = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (ov32 !== 1'b0) begin n_fail++; $display("FAIL midrst_during got %b want 0", ov32); end
      end
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) begin
            n_checks++;
            if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", rdy32); end
         end
         n_checks++;
         if (ov32 !== 1'b0) begin n_fail++; $display("FAIL midrst_stale[%0d] got %b want 0", k, ov32); end
      end
      send_one(64'h0000_0000_0012_3457, 1'b0, 2'd0, od, oi, lat);
      ex = ref_itof(64'h0000_0000_0012_3457, 32, 1'b0, 2'd0);
      n_checks += 2;
      if (lat != 3) begin n_fail++; $display("FAIL midrst_latency got %0d want 3", lat); end
      if ({oi, od} !== ex) begin n_fail++; $display("FAIL midrst_result got %h want %h", {oi, od}, ex); end
   endtask

   task automatic test_random(input int n);
      logic [32:0] sb [3][$];
      logic [32:0] obs [3];
      logic vv [3];
      logic [32:0] e;
      int ws [3] = '{16, 32, 64};
      for (int c = 0; c < n + 20; c++) begin
         @(negedge clk);
         in_valid = (c < n) && ($urandom_range(0, 3) != 0);
         out_ready = (c >= n) || ($urandom_range(0, 3) != 0);
         in_signed = 1'($urandom_range(0, 1));
         in_rm = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: din = 64'd0;
            1: din = 64'($urandom_range(0, 300));
            2: din = 64'd1 << $urandom_range(0, 63);
            3: din = '1;
            4: din = -64'($urandom_range(1, 300));
            default: din = {$urandom, $urandom};
         endcase
         #1;
         vv[0] = ov16; obs[0] = {oi16, od16};
         vv[1] = ov32; obs[1] = {oi32, od32};
         vv[2] = ov64; obs[2] = {oi64, od64};
         for (int k = 0; k < 3; k++)
            if (vv[k] && out_ready) begin
               n_checks++;
               if (sb[k].size() == 0) begin
                  n_fail++;
                  $display("FAIL rand_extra_w%0d got %h want none", ws[k], obs[k]);
               end else begin
                  e = sb[k].pop_front();
                  if (obs[k] !== e) begin n_fail++; $display("FAIL rand_w%0d got %h want %h", ws[k], obs[k], e); end
               end
            end
         if (in_valid && rdy32)
            for (int k = 0; k < 3; k++) sb[k].push_back(ref_itof(din, ws[k], in_signed, in_rm));
      end
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (sb[k].size() != 0) begin n_fail++; $display("FAIL rand_lost_w%0d got %0d pending want 0", ws[k], sb[k].size()); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midflight();
      test_random(3000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/itof_stream.md
ITOF_STREAM -- requirements
Module: itof_stream

Interface
REQ-001 Parameter IN_W, default 32, integer operand width; legal range 8..64.
REQ-002 Parameter LAT, fixed at 3, pipeline depth in cycles; not overridable.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operand present.
REQ-006 in_ready  output  1  block accepts operand this cycle.
REQ-007 in_data  input  IN_W  integer operand.
REQ-008 in_signed  input  1  1 = two's-complement operand, 0 = unsigned.
REQ-009 in_rm  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  32  IEEE-754 binary32 result.
REQ-013 out_inexact  output  1  result differs from exact integer value.

Function
REQ-014 Pipeline advance enable = ~out_valid | out_ready; in_ready SHALL equal this enable.
REQ-015 Operand accepted when in_valid & in_ready; result appears on out_valid exactly LAT cycles later when out_ready is held high.
REQ-016 With the enable low, all stage registers, including their valid bits, SHALL hold; out_data and out_inexact stay stable while out_valid & ~out_ready.
REQ-017 Results leave in acceptance order; no drop, no duplication; bubbles propagate as invalid stages.
REQ-018 Stage 1: sign = in_signed & in_data[IN_W-1]; magnitude = |in_data| as IN_W-bit unsigned, so the most negative signed value maps to 2^(IN_W-1) without overflow; rm and sign registered alongside.
REQ-019 Stage 2: leading-one position p via LZC; normalise so the leading one is dropped; keep 23 mantissa bits, a guard bit, and a sticky bit (OR of all lower bits).
REQ-020 Stage 3: increment = RNE: guard & (sticky | mant_lsb); RTZ: 0; RDN: sign & (guard | sticky); RUP: ~sign & (guard | sticky).
REQ-021 Mantissa carry-out on increment SHALL set mantissa 0 and raise the exponent by 1.
REQ-022 Exponent = 127 + p (+1 on carry); overflow is impossible for IN_W <= 64.
REQ-023 out_inexact = guard | sticky; for IN_W <= 24 it is always 0.
REQ-024 Zero operand SHALL give 0x00000000 (+0) with inexact 0 in every rounding mode.
REQ-025 in_signed = 0 SHALL ignore the MSB as a sign; in_rm applies per operand, so mixed modes in flight are legal.

Reset
REQ-026 While reset = 0 at a clock edge, all stage valid bits clear, out_valid = 0, out_data = 0, and out_inexact = 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operands; no result emerges from them after reset deasserts.
REQ-028 in_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-029 Shared package fpu_pkg SHALL hold the rounding-mode constants (RM_RNE, RM_RTZ, RM_RDN, RM_RUP), FP32_BIAS = 127, FP32_MANT_W = 23, and FP32_EXP_W = 8.
REQ-030 One sub-module itof_lzc (parameterised width, outputs leading-zero count and all-zero flag) SHALL be instantiated in stage 2.
REQ-031 No combinational path from in_valid or in_data to any output; in_ready depends only on out_valid and out_ready.

Verification
REQ-032 IN_W=32 signed 0x7FFFFFFF: RNE -> 0x4F000000, inexact 1; RTZ -> 0x4EFFFFFF, inexact 1.
REQ-033 Signed 0x80000000 RNE -> 0xCF000000, inexact 0; unsigned 0xFFFFFFFF RNE -> 0x4F800000, inexact 1; 0 in all four modes -> 0x00000000, inexact 0.
REQ-034 Ties: 0x01000001 RNE -> 0x4B800000; 0x01000003 RNE -> 0x4B800002; 0x01000001 RUP -> 0x4B800001; signed -(0x01000001) RDN -> 0xCB800001.
REQ-035 Backpressure: send 5 back-to-back operands, hold out_ready = 0 for 6 cycles -> in_ready drops after the pipeline fills, outputs stay stable, then all 5 results emerge in order with no loss.
REQ-036 Reset pulse with 2 operands in flight -> out_valid = 0 through reset and no stale result afterwards; a new operand then appears after 3 cycles.
REQ-037 Random regression for IN_W = 16, 32 and 64 against a reference model, all modes, random in_valid/out_ready -> bit-exact out_data and out_inexact.
